adam_fpga_rst_seq: RTL
======================

# adam_fpga_rst_seq

Board-level reset sequencer sitting directly upstream of the FPGA top-level's source sequencing domain. It conditions the board reset button and the clocking primitive's lock signal, then releases a vector of active-high domain resets in a fixed order with programmable gaps: source domain first, then lsdom, then hsdom. It replaces the ad-hoc 16-cycle counter in the top-level wrapper. It also records why the last reset occurred and accepts a software/debug reset request.

## Interface
- `NO_STAGES`, default 3: number of staged reset outputs. Stage 0 is released first. Must be ≥ 1.
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles the synchronized lock must stay high before sequencing starts. Must be ≥ 1.
- `STAGE_GAP`, default 16: cycles between successive stage releases. Must be ≥ 1.
- `HOLD_CYCLES`, default 8: minimum cycles all resets stay asserted after a lock loss or software reset. Must be ≥ 1.
- `clk  in  1`: free-running board clock.
- `rstn  in  1`: board reset; synchronous, active-low.
- `lock_i  in  1`: clocking primitive lock. Asynchronous; synchronized internally with 2 flops.
- `sw_rst_req  in  1`: single-cycle reset request, synchronous to clk.
- `rst_o  out  NO_STAGES`: active-high domain resets.
- `rst_done  out  1`: high once every stage is released.
- `rst_cause  out  2`: cause of the last reset. 0 = rstn, 1 = lock loss, 2 = sw_rst_req. 3 is never driven.

## Operation
- States: RESET, WAIT_LOCK, RELEASE, RUN, HOLD.
- Counters:
  - `cnt`: width clog2(max(DEBOUNCE_CYCLES, STAGE_GAP, HOLD_CYCLES)) + 1. Saturation is never needed; it is cleared on every state change.
  - `stage_idx`: width clog2(NO_STAGES) + 1.
- `lock_s` is `lock_i` after two flops. Both synchronizer flops reset to 0 on rstn.
- **rstn low at a clk edge**, from any state: the block enters RESET.
  - rst_o = all ones, rst_done = 0, rst_cause = 0, cnt = 0, stage_idx = 0.
  - Synchronizer flops = 0.
- **RESET**: the first edge with rstn high moves the FSM to WAIT_LOCK.
- **WAIT_LOCK**:
  - `lock_s` = 1: cnt increments.
  - `lock_s` = 0: cnt clears.
  - When `lock_s` = 1 and cnt == DEBOUNCE_CYCLES-1, the FSM moves to RELEASE with cnt = 0 and stage_idx = 0.
  - sw_rst_req is ignored in this state.
- **RELEASE**:
  - cnt increments each cycle.
  - When cnt == STAGE_GAP-1: rst_o[stage_idx] is cleared, stage_idx increments, and cnt clears.
  - Releasing stage NO_STAGES-1 moves the FSM to RUN. rst_done rises on that same edge.
- **RUN**: rst_o = 0 and rst_done = 1.
- **Abort from RELEASE or RUN**: `lock_s` = 0 or sw_rst_req = 1 moves the FSM to HOLD on that edge.
  - rst_o is set to all ones and rst_done is cleared.
  - rst_cause = 1 if `lock_s` = 0, otherwise 2. Lock loss wins when both occur in the same cycle.
- **HOLD**:
  - rst_o stays all ones; cnt increments.
  - When cnt == HOLD_CYCLES-1, the FSM moves to WAIT_LOCK with cnt = 0.
  - Further sw_rst_req or lock loss in HOLD does not restart the hold and does not change rst_cause.
- rst_o bits only clear in stage order. They are never released out of order and never released while the FSM is outside RELEASE/RUN.
- rst_cause is updated only on entry to RESET or HOLD; otherwise it holds.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- rstn to rst_o: rst_o is asserted at the first edge where rstn = 0 is sampled.
- lock_i to lock_s: 2 cycles.
- Release timing, with rstn rising before edge 0 and lock_i stably high:
  - Edge 0: RESET → WAIT_LOCK.
  - lock_s is high from edge 2.
  - Entry to RELEASE at edge 2 + DEBOUNCE_CYCLES - 1.
  - rst_o[k] falls STAGE_GAP*(k+1) edges after RELEASE entry.
  - rst_done rises on the same edge as rst_o[NO_STAGES-1].
- Abort latency:
  - sw_rst_req: rst_o asserts 1 edge after the request.
  - lock_i low: rst_o asserts 3 edges after lock_i falls (2 synchronizer stages plus the FSM edge).
- A lock glitch shorter than DEBOUNCE_CYCLES in WAIT_LOCK restarts the debounce count. No rst_o bit changes.
- rstn asserted mid-RELEASE or mid-HOLD: the block enters RESET on that edge, and all partial progress is discarded.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, STAGE_GAP=2, HOLD_CYCLES=3, NO_STAGES=3.
1. **Power-on release**: rstn low for 5 cycles, lock_i high throughout, release rstn before edge 0.
   - RELEASE entered at edge 5.
   - rst_o = 3'b110 at edge 7, 3'b100 at edge 9, 3'b000 at edge 11.
   - rst_done = 1 at edge 11; rst_cause = 0.
2. **Lock debounce**: during WAIT_LOCK, lock_i goes high 3 cycles, low 1, then high.
   - rst_o stays 3'b111 until 4 consecutive lock_s-high cycles are seen; release then follows the scenario 1 spacing.
3. **Software reset**: in RUN, pulse sw_rst_req for 1 cycle.
   - rst_o = 3'b111 and rst_done = 0 on the next edge; rst_cause = 2.
   - After 3 HOLD cycles the FSM re-enters WAIT_LOCK, then repeats the full release.
4. **Simultaneous abort**: in RUN, drop lock_i and pulse sw_rst_req timed so lock_s = 0 and sw_rst_req = 1 in the same cycle.
   - rst_cause = 1.
   - The FSM stays in WAIT_LOCK until lock_i returns.
5. **Mid-sequence rstn**: assert rstn low when rst_o = 3'b110.
   - rst_o = 3'b111 at that edge; rst_cause = 0.
   - After rstn rises, a full debounce and release restarts.
6. **Lock loss during RELEASE**: drop lock_i after stage 0 is released.
   - rst_o = 3'b111 exactly 3 edges after lock_i falls; rst_cause = 1.
   - No stage is released during HOLD.

Source files
------------

// File: rtl/adam_fpga_rst_seq.sv
// Board-level reset sequencer: conditions rstn and the clocking lock, then releases
// staged active-high domain resets in order, tracking the cause of the last reset.
`timescale 1ns/1ps

module adam_fpga_rst_seq #(
  parameter int NO_STAGES       = 3,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STAGE_GAP       = 16,
  parameter int HOLD_CYCLES     = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 lock_i,
  input  logic                 sw_rst_req,
  output logic [NO_STAGES-1:0] rst_o,
  output logic                 rst_done,
  output logic [1:0]           rst_cause
);

  localparam int MAX_AB  = (DEBOUNCE_CYCLES > STAGE_GAP) ? DEBOUNCE_CYCLES : STAGE_GAP;
  localparam int MAX_CNT = (MAX_AB > HOLD_CYCLES) ? MAX_AB : HOLD_CYCLES;
  localparam int CW      = $clog2(MAX_CNT) + 1;
  localparam int SW      = $clog2(NO_STAGES) + 1;

  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NO_STAGES - 1);

  localparam logic [1:0] CAUSE_RSTN = 2'd0;
  localparam logic [1:0] CAUSE_LOCK = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;

  localparam logic [NO_STAGES-1:0] ALL_ON  = {NO_STAGES{1'b1}};
  localparam logic [NO_STAGES-1:0] ALL_OFF = {NO_STAGES{1'b0}};

  typedef enum logic [2:0] {
    ST_RESET     = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_RELEASE   = 3'd2,
    ST_RUN       = 3'd3,
    ST_HOLD      = 3'd4
  } state_e;

  state_e               state_r;
  state_e               state_s;
  logic [CW-1:0]        cnt_r;
  logic [CW-1:0]        cnt_s;
  logic [SW-1:0]        stage_idx_r;
  logic [SW-1:0]        stage_idx_s;
  logic [NO_STAGES-1:0] rst_s;
  logic                 done_s;
  logic [1:0]           cause_s;
  logic [NO_STAGES-1:0] stage_mask_s;
  logic                 lock_meta_r;
  logic                 lock_s;
  logic                 abort_s;

  // Two-flop synchronizer for the asynchronous lock input
  always_ff @(posedge clk) begin
    if (!rstn) begin
      lock_meta_r <= 1'b0;
      lock_s      <= 1'b0;
    end else begin
      lock_meta_r <= lock_i;
      lock_s      <= lock_meta_r;
    end
  end

  assign abort_s = ~lock_s | sw_rst_req;

  // One-hot mask selecting the stage currently being released
  always_comb begin
    stage_mask_s = ALL_OFF;
    for (int i = 0; i < NO_STAGES; i++) begin
      if (SW'(i) == stage_idx_r) begin
        stage_mask_s[i] = 1'b1;
      end else begin
        stage_mask_s[i] = 1'b0;
      end
    end
  end

  // Next-state and next-output logic; lock loss outranks a software request
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    stage_idx_s = stage_idx_r;
    rst_s       = rst_o;
    done_s      = rst_done;
    cause_s     = rst_cause;
    case (state_r)
      ST_RESET: begin
        state_s     = ST_WAIT_LOCK;
        cnt_s       = {CW{1'b0}};
        stage_idx_s = {SW{1'b0}};
        rst_s       = ALL_ON;
        done_s      = 1'b0;
      end
      ST_WAIT_LOCK: begin
        rst_s  = ALL_ON;
        done_s = 1'b0;
        if (lock_s) begin
          if (cnt_r == DEB_LAST) begin
            state_s     = ST_RELEASE;
            cnt_s       = {CW{1'b0}};
            stage_idx_s = {SW{1'b0}};
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          cnt_s = {CW{1'b0}};
        end
      end
      ST_RELEASE: begin
        if (abort_s) begin
          state_s     = ST_HOLD;
          cnt_s       = {CW{1'b0}};
          stage_idx_s = {SW{1'b0}};
          rst_s       = ALL_ON;
          done_s      = 1'b0;
          cause_s     = lock_s ? CAUSE_SW : CAUSE_LOCK;
        end else if (cnt_r == GAP_LAST) begin
          rst_s       = rst_o & ~stage_mask_s;
          cnt_s       = {CW{1'b0}};
          stage_idx_s = stage_idx_r + SW'(1);
          if (stage_idx_r == LAST_STAGE) begin
            state_s = ST_RUN;
            done_s  = 1'b1;
          end else begin
            state_s = ST_RELEASE;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_RUN: begin
        if (abort_s) begin
          state_s     = ST_HOLD;
          cnt_s       = {CW{1'b0}};
          stage_idx_s = {SW{1'b0}};
          rst_s       = ALL_ON;
          done_s      = 1'b0;
          cause_s     = lock_s ? CAUSE_SW : CAUSE_LOCK;
        end else begin
          rst_s  = ALL_OFF;
          done_s = 1'b1;
        end
      end
      ST_HOLD: begin
        rst_s  = ALL_ON;
        done_s = 1'b0;
        if (cnt_r == HOLD_LAST) begin
          state_s = ST_WAIT_LOCK;
          cnt_s   = {CW{1'b0}};
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s     = ST_RESET;
        cnt_s       = {CW{1'b0}};
        stage_idx_s = {SW{1'b0}};
        rst_s       = ALL_ON;
        done_s      = 1'b0;
      end
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r     <= ST_RESET;
      cnt_r       <= {CW{1'b0}};
      stage_idx_r <= {SW{1'b0}};
      rst_o       <= ALL_ON;
      rst_done    <= 1'b0;
      rst_cause   <= CAUSE_RSTN;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      stage_idx_r <= stage_idx_s;
      rst_o       <= rst_s;
      rst_done    <= done_s;
      rst_cause   <= cause_s;
    end
  end

endmodule
